fe_stream_merger: RTL and testbench

//  Merges the per-front-end 32-bit FIFO streams (fei4_rx outputs) into one 32-bit word stream
//  for the fifo_32_to_8 TCP TX buffer. Round-robin grant with bounded bursts; one registered output stage.

---
 rtl/fe_stream_merger.sv | 128 ++++++++++++
 tb/tb_fe_stream_merger.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fe_stream_merger.sv
// fe_stream_merger
// Merges the per-front-end FWFT FIFO streams into a single word stream for the
// TCP TX buffer. Channels are served round-robin with bounded bursts. The output
// is a single register stage. Everything is clocked on BUS_CLK with a synchronous reset.

module fe_stream_merger #(
    parameter int N_CH      = 4,
    parameter int DSIZE     = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                    BUS_CLK,
    input  logic                    BUS_RST,
    input  logic [N_CH-1:0]         CH_EN,
    input  logic [N_CH-1:0]         FIFO_EMPTY,
    input  logic [N_CH*DSIZE-1:0]   FIFO_DATA,
    output logic [N_CH-1:0]         FIFO_READ,
    input  logic                    OUT_READY,
    output logic                    OUT_WRITE,
    output logic [DSIZE-1:0]        OUT_DATA,
    output logic [N_CH-1:0]         GRANT,
    output logic [31:0]             WORD_CNT
);

    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t            state;
    logic [IW-1:0]     last;
    logic [BW-1:0]     burst_cnt;

    logic [N_CH-1:0]   req;
    logic [IW-1:0]     sel;
    logic              sel_found;
    logic [IW-1:0]     rr_cand;
    logic [N_CH-1:0]   sel_onehot;

    logic              load_ok;
    logic              grant_empty;
    logic              grant_en;
    logic [DSIZE-1:0]  grant_data;
    logic              pop;
    logic              burst_full;
    logic              burst_exit;

    // Round-robin search: the first requesting channel after the last one granted wins
    always_comb begin
        req       = CH_EN & ~FIFO_EMPTY;
        sel       = '0;
        sel_found = 1'b0;
        rr_cand   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            rr_cand = IW'((int'(last) + k) % N_CH);
            if (!sel_found && req[rr_cand]) begin
                sel       = rr_cand;
                sel_found = 1'b1;
            end
        end
        sel_onehot = N_CH'(1) << sel;
    end

    // Pop decision for the granted channel; the output register must be free next cycle
    always_comb begin
        load_ok     = !OUT_WRITE || OUT_READY;
        grant_empty = FIFO_EMPTY[last];
        grant_en    = CH_EN[last];
        grant_data  = FIFO_DATA[int'(last)*DSIZE +: DSIZE];
        pop         = (state == BURST) && !BUS_RST && load_ok && !grant_empty
                      && grant_en && (burst_cnt < MAX_B);
        burst_full  = pop && ((burst_cnt + BW'(1)) == MAX_B);
        burst_exit  = grant_empty || !grant_en || (burst_cnt >= MAX_B) || burst_full;
        FIFO_READ   = pop ? GRANT : '0;
    end

    // Arbitration FSM, output register and transfer counter
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state     <= IDLE;
            last      <= IW'(N_CH - 1);
            burst_cnt <= '0;
            GRANT     <= '0;
            OUT_WRITE <= 1'b0;
            OUT_DATA  <= '0;
            WORD_CNT  <= '0;
        end else begin
            if (OUT_WRITE && OUT_READY) begin
                WORD_CNT <= WORD_CNT + 32'd1;
            end

            if (pop) begin
                OUT_DATA  <= grant_data;
                OUT_WRITE <= 1'b1;
            end else if (OUT_READY) begin
                OUT_WRITE <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (sel_found) begin
                        GRANT     <= sel_onehot;
                        last      <= sel;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (pop) begin
                        burst_cnt <= burst_cnt + BW'(1);
                    end
                    if (burst_exit) begin
                        GRANT <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    GRANT <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fe_stream_merger.sv
// tb_fe_stream_merger
// Drives modelled FWFT FIFOs into the merger, keeps per-channel expected word
// queues, and checks the merged stream in a separate negedge monitor.

module tb_fe_stream_merger;

    localparam int N_CH      = 4;
    localparam int DSIZE     = 32;
    localparam int MAX_BURST = 16;

    logic                  BUS_CLK = 1'b0;
    logic                  BUS_RST;
    logic [N_CH-1:0]       CH_EN;
    logic [N_CH-1:0]       FIFO_EMPTY;
    logic [N_CH*DSIZE-1:0] FIFO_DATA;
    logic [N_CH-1:0]       FIFO_READ;
    logic                  OUT_READY;
    logic                  OUT_WRITE;
    logic [DSIZE-1:0]      OUT_DATA;
    logic [N_CH-1:0]       GRANT;
    logic [31:0]           WORD_CNT;

    fe_stream_merger #(
        .N_CH(N_CH),
        .DSIZE(DSIZE),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .BUS_CLK(BUS_CLK),
        .BUS_RST(BUS_RST),
        .CH_EN(CH_EN),
        .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_DATA(FIFO_DATA),
        .FIFO_READ(FIFO_READ),
        .OUT_READY(OUT_READY),
        .OUT_WRITE(OUT_WRITE),
        .OUT_DATA(OUT_DATA),
        .GRANT(GRANT),
        .WORD_CNT(WORD_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    logic [DSIZE-1:0] fifoQ [N_CH][$];
    logic [DSIZE-1:0] expQ  [N_CH][$];
    int               outLog[$];
    int               seqNo [N_CH];
    int               vectors = 0;
    int               miscompares = 0;
    int               expCnt = 0;

    logic             prevStall = 1'b0;
    logic [DSIZE-1:0] prevData = '0;
    logic [N_CH-1:0]  prevGrant = '0;
    int               waitGrants [N_CH];
    int               monCh;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Present the head of each modelled FIFO to the DUT
    task automatic refreshFifos();
        for (int i = 0; i < N_CH; i++) begin
            FIFO_EMPTY[i] = (fifoQ[i].size() == 0);
            FIFO_DATA[i*DSIZE +: DSIZE] = (fifoQ[i].size() == 0) ? '0 : fifoQ[i][0];
        end
    endtask

    // Words carry their channel in the top nibble so the monitor can route them
    task automatic pushWord(input int ch);
        logic [DSIZE-1:0] w;
        w = (32'(ch) << 28) | ((32'(seqNo[ch]) & 32'hFFF) << 16) | ($urandom & 32'hFFFF);
        seqNo[ch]++;
        fifoQ[ch].push_back(w);
        expQ[ch].push_back(w);
        refreshFifos();
    endtask

    // One clock: sample the pop strobes mid-cycle, then apply them to the FIFO model
    task automatic applyStimulus(output logic [N_CH-1:0] rd);
        @(negedge BUS_CLK);
        rd = FIFO_READ;
        @(posedge BUS_CLK);
        #1;
        for (int i = 0; i < N_CH; i++) begin
            if (rd[i]) begin
                checkOutput("pop_nonempty", 64'(fifoQ[i].size() > 0), 64'd1);
                if (fifoQ[i].size() > 0) void'(fifoQ[i].pop_front());
            end
        end
        refreshFifos();
    endtask

    function automatic int totalExpected();
        int s = 0;
        for (int i = 0; i < N_CH; i++) s += expQ[i].size();
        return s;
    endfunction

    function automatic int countCh(input int ch);
        int s = 0;
        foreach (outLog[k]) if (outLog[k] == ch) s++;
        return s;
    endfunction

    task automatic runUntilDrained(input string name, input int maxCycles);
        logic [N_CH-1:0] rd;
        int n = 0;
        while ((totalExpected() != 0 || OUT_WRITE) && n < maxCycles) begin
            applyStimulus(rd);
            n++;
        end
        checkOutput(name, 64'(totalExpected()), 64'd0);
    endtask

    task automatic doReset();
        logic [N_CH-1:0] rd;
        BUS_RST = 1'b1;
        applyStimulus(rd);
        checkOutput("rst_no_read", 64'(rd), 64'd0);
        checkOutput("rst_out_write", 64'(OUT_WRITE), 64'd0);
        checkOutput("rst_grant", 64'(GRANT), 64'd0);
        checkOutput("rst_word_cnt", 64'(WORD_CNT), 64'd0);
        BUS_RST = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            fifoQ[i].delete();
            expQ[i].delete();
        end
        refreshFifos();
    endtask

    // Monitor: scoreboard compare on every transfer plus stall and fairness rules
    always @(negedge BUS_CLK) begin
        if (BUS_RST) begin
            expCnt    = 0;
            prevStall = 1'b0;
            prevGrant = '0;
            for (int i = 0; i < N_CH; i++) waitGrants[i] = 0;
        end else begin
            checkOutput("word_cnt", 64'(WORD_CNT), 64'(expCnt));
            checkOutput("read_onehot0", 64'($onehot0(FIFO_READ)), 64'd1);
            if (prevStall) begin
                checkOutput("stall_hold_write", 64'(OUT_WRITE), 64'd1);
                checkOutput("stall_hold_data", 64'(OUT_DATA), 64'(prevData));
            end
            if (OUT_WRITE && !OUT_READY) begin
                checkOutput("stall_no_pop", 64'(FIFO_READ), 64'd0);
            end
            if (OUT_WRITE && OUT_READY) begin
                monCh = int'(OUT_DATA[31:28]);
                if (monCh < N_CH && expQ[monCh].size() > 0) begin
                    checkOutput("stream_word", 64'(OUT_DATA), 64'(expQ[monCh].pop_front()));
                end else begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_word: got %0h, expected no output (t=%0t)", OUT_DATA, $time);
                end
                outLog.push_back(monCh);
                expCnt++;
            end
            prevStall = OUT_WRITE && !OUT_READY;
            prevData  = OUT_DATA;

            // A continuously requesting channel sees at most N_CH-1 other grants;
            // one extra is tolerated because a request may appear just after arbitration.
            for (int i = 0; i < N_CH; i++) begin
                if (!(CH_EN[i] && !FIFO_EMPTY[i]) || GRANT[i]) begin
                    waitGrants[i] = 0;
                end else if (GRANT != '0 && prevGrant == '0) begin
                    waitGrants[i]++;
                    checkOutput("rr_fairness", 64'(waitGrants[i] <= N_CH), 64'd1);
                end
            end
            prevGrant = GRANT;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N_CH-1:0]  rd;
        logic [DSIZE-1:0] w [3];
        logic [DSIZE-1:0] held;
        int               expOrder[$];
        int               rem [N_CH];
        int               n;
        int               pops1;
        logic             sawG2;

        for (int i = 0; i < N_CH; i++) begin
            seqNo[i] = 0;
            waitGrants[i] = 0;
        end
        BUS_RST   = 1'b1;
        CH_EN     = '1;
        OUT_READY = 1'b1;
        refreshFifos();
        applyStimulus(rd);
        doReset();
        checkOutput("rst_out_data", 64'(OUT_DATA), 64'd0);

        // Test 1: single channel, three words
        $display("[TB] test 1: ch2 three words");
        for (int k = 0; k < 3; k++) pushWord(2);
        for (int k = 0; k < 3; k++) w[k] = fifoQ[2][k];
        applyStimulus(rd);
        checkOutput("t1_idle_no_pop", 64'(rd), 64'd0);
        checkOutput("t1_grant", 64'(GRANT), 64'b0100);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(rd);
            checkOutput("t1_pop", 64'(rd), 64'b0100);
            checkOutput("t1_out_write", 64'(OUT_WRITE), 64'd1);
            checkOutput("t1_out_data", 64'(OUT_DATA), 64'(w[k]));
        end
        applyStimulus(rd);
        checkOutput("t1_no_more_pop", 64'(rd), 64'd0);
        checkOutput("t1_grant_released", 64'(GRANT), 64'd0);
        applyStimulus(rd);
        checkOutput("t1_word_cnt", 64'(WORD_CNT), 64'd3);

        // Test 2: all channels loaded, bursts must follow round-robin order
        $display("[TB] test 2: four channels x 20 words");
        doReset();
        outLog.delete();
        for (int i = 0; i < N_CH; i++) begin
            for (int k = 0; k < 20; k++) pushWord(i);
            rem[i] = 20;
        end
        while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
            for (int i = 0; i < N_CH; i++) begin
                n = (rem[i] < MAX_BURST) ? rem[i] : MAX_BURST;
                for (int k = 0; k < n; k++) expOrder.push_back(i);
                rem[i] -= n;
            end
        end
        runUntilDrained("t2_drain", 400);
        checkOutput("t2_count", 64'(outLog.size()), 64'(expOrder.size()));
        foreach (expOrder[k]) begin
            if (k < outLog.size()) checkOutput("t2_order", 64'(outLog[k]), 64'(expOrder[k]));
        end
        applyStimulus(rd);
        checkOutput("t2_word_cnt", 64'(WORD_CNT), 64'd80);

        // Test 3: backpressure mid-burst
        $display("[TB] test 3: backpressure");
        for (int k = 0; k < 10; k++) pushWord(0);
        n = 0;
        while (expQ[0].size() > 7 && n < 50) begin
            applyStimulus(rd);
            n++;
        end
        checkOutput("t3_reached_mid_burst", 64'(expQ[0].size() <= 7), 64'd1);
        OUT_READY = 1'b0;
        held = OUT_DATA;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(rd);
            checkOutput("t3_no_pop", 64'(rd), 64'd0);
            checkOutput("t3_hold_write", 64'(OUT_WRITE), 64'd1);
            checkOutput("t3_hold_data", 64'(OUT_DATA), 64'(held));
        end
        OUT_READY = 1'b1;
        runUntilDrained("t3_drain", 100);

        // Test 4: channel disabled mid-burst, then re-enabled
        $display("[TB] test 4: disable mid-burst");
        outLog.delete();
        for (int k = 0; k < 10; k++) pushWord(1);
        for (int k = 0; k < 4; k++) pushWord(2);
        pops1 = 0;
        n = 0;
        while (pops1 < 3 && n < 60) begin
            applyStimulus(rd);
            if (rd[1]) pops1++;
            n++;
        end
        CH_EN[1] = 1'b0;
        sawG2 = 1'b0;
        n = 0;
        while ((expQ[2].size() != 0 || OUT_WRITE) && n < 80) begin
            applyStimulus(rd);
            if (rd[1]) pops1++;
            if (GRANT == 4'b0100) sawG2 = 1'b1;
            n++;
        end
        checkOutput("t4_pops_ch1", 64'(pops1), 64'd3);
        checkOutput("t4_ch1_out", 64'(countCh(1)), 64'd3);
        checkOutput("t4_ch1_left", 64'(fifoQ[1].size()), 64'd7);
        checkOutput("t4_grant_moved", 64'(sawG2), 64'd1);
        CH_EN[1] = 1'b1;
        runUntilDrained("t4_drain", 100);
        checkOutput("t4_ch1_total", 64'(countCh(1)), 64'd10);

        // Test 5: reset mid-burst restarts arbitration at ch0
        $display("[TB] test 5: reset mid-burst");
        for (int k = 0; k < 8; k++) pushWord(1);
        pops1 = 0;
        n = 0;
        while (pops1 < 3 && n < 60) begin
            applyStimulus(rd);
            if (rd[1]) pops1++;
            n++;
        end
        checkOutput("t5_mid_burst_write", 64'(OUT_WRITE), 64'd1);
        doReset();
        for (int k = 0; k < 3; k++) begin
            pushWord(0);
            pushWord(3);
        end
        applyStimulus(rd);
        checkOutput("t5_grant_ch0", 64'(GRANT), 64'b0001);
        runUntilDrained("t5_drain", 100);

        // Test 6: random fill, backpressure and enable toggling
        $display("[TB] test 6: random traffic");
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                n = int'($urandom_range(0, N_CH - 1));
                if (fifoQ[n].size() < 40) pushWord(n);
            end
            OUT_READY = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) == 0) begin
                n = int'($urandom_range(0, N_CH - 1));
                CH_EN[n] = ~CH_EN[n];
            end
            applyStimulus(rd);
        end
        CH_EN = '1;
        OUT_READY = 1'b1;
        runUntilDrained("t6_drain", 2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
